// File: rtl/instruction_queue_reg_pkg.sv
// ============================================================================
// Module   : instruction_queue_reg_pkg
// Brief    : Shared widths, opcode constants and the parity helper used by
//            the instruction queue and its neighbours in decode/control.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package instruction_queue_reg_pkg;

  // Default geometry of the instruction word and prefetch queue
  localparam int c_INSTR_W_DEF = 8;
  localparam int c_OP_W_DEF    = 4;
  localparam int c_REG_W_DEF   = 2;
  localparam int c_DEPTH_DEF   = 4;

  // Opcode encodings shared with decode and control
  localparam logic [3:0] c_OP_LOAD = 4'b1011;
  localparam logic [3:0] c_OP_ADD  = 4'b0100;

  // Even-parity bit of a word (zero-extended to 64 bits by the caller)
  function automatic logic even_par(input logic [63:0] word);
    return ^word;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ir_fifo.sv
// ============================================================================
// Module   : ir_fifo
// Brief    : Power-of-two circular prefetch queue with wrap-bit pointers,
//            occupancy count and synchronous flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

import instruction_queue_reg_pkg::*;

module ir_fifo #(
  parameter int WIDTH = c_INSTR_W_DEF,
  parameter int DEPTH = c_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_PW = c_AW + 1;
  localparam int c_CW = $clog2(DEPTH+1);

  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("ir_fifo: DEPTH must be a power of two and >= 2");
    end
  endgenerate

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_PW-1:0]  r_wr_ptr;
  logic [c_PW-1:0]  r_rd_ptr;
  logic [c_CW-1:0]  r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  // Same index with differing wrap bits means the writer has lapped the reader
  assign full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign empty   = (r_wr_ptr == r_rd_ptr);
  assign rd_data = r_mem[r_rd_ptr[c_AW-1:0]];
  assign count   = r_count;

  // Flush overrides both ports so nothing is captured or consumed that cycle
  assign w_push_ok = push && !full && !flush;
  assign w_pop_ok  = pop && !empty && !flush;

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_PW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + c_PW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[c_AW-1:0]] <= wr_data;
  end

endmodule

`default_nettype wire

// File: rtl/instruction_queue_reg.sv
// ============================================================================
// Module   : instruction_queue_reg
// Brief    : Prefetch queue in front of the instruction register. Loads the
//            queue head into the IR on request, splits it into op_code,
//            reg_sel and data, and flags loads attempted on an empty queue.
//            Optional macro IR_PARITY_EN adds per-entry even parity
//            (instruction_par in, par_err out).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

import instruction_queue_reg_pkg::*;

module instruction_queue_reg #(
  parameter  int INSTR_W = c_INSTR_W_DEF,
  parameter  int OP_W    = c_OP_W_DEF,
  parameter  int REG_W   = c_REG_W_DEF,
  parameter  int DEPTH   = c_DEPTH_DEF,
  localparam int DATA_W  = INSTR_W - OP_W - REG_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INSTR_W-1:0]         instruction_in,
`ifdef IR_PARITY_EN
  input  logic                       instruction_par,
  output logic                       par_err,
`endif
  input  logic                       ir_load_en,
  input  logic                       flush,
  output logic [OP_W-1:0]            op_code,
  output logic [REG_W-1:0]           reg_sel,
  output logic [DATA_W-1:0]          data,
  output logic                       ir_valid,
  output logic                       underflow,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  generate
    if (DATA_W < 1) begin : g_bad_data_w
      $error("instruction_queue_reg: INSTR_W must exceed OP_W + REG_W");
    end
  endgenerate

`ifdef IR_PARITY_EN
  localparam int c_FW = INSTR_W + 1;
`else
  localparam int c_FW = INSTR_W;
`endif

  logic [c_FW-1:0]    w_fifo_wr;
  logic [c_FW-1:0]    w_fifo_rd;
  logic [INSTR_W-1:0] w_head_word;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic [INSTR_W-1:0] r_ir;
  logic               r_ir_valid;
  logic               r_underflow;

`ifdef IR_PARITY_EN
  logic w_head_par;
  logic r_par_err;
  assign w_fifo_wr  = {instruction_par, instruction_in};
  assign w_head_par = w_fifo_rd[INSTR_W];
`else
  assign w_fifo_wr  = instruction_in;
`endif
  assign w_head_word = w_fifo_rd[INSTR_W-1:0];

  // A full queue refuses pushes even when a load frees a slot this cycle
  assign in_ready = !w_full;
  assign w_push   = in_valid && !w_full;
  assign w_pop    = ir_load_en && !w_empty;

  ir_fifo #(
    .WIDTH (c_FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (w_push),
    .pop     (w_pop),
    .flush   (flush),
    .wr_data (w_fifo_wr),
    .rd_data (w_fifo_rd),
    .full    (w_full),
    .empty   (w_empty),
    .count   (count)
  );

  // IR load, validity tracking and one-cycle underflow pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ir        <= '0;
      r_ir_valid  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_underflow <= 1'b0;
      if (flush) begin
        r_ir       <= '0;
        r_ir_valid <= 1'b0;
      end else if (ir_load_en) begin
        if (w_empty) begin
          r_ir_valid  <= 1'b0;
          r_underflow <= 1'b1;
        end else begin
          r_ir       <= w_head_word;
          r_ir_valid <= 1'b1;
        end
      end
    end
  end

`ifdef IR_PARITY_EN
  // Parity verdict refreshes on each successful load and holds otherwise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_par_err <= 1'b0;
    end else if (flush) begin
      r_par_err <= 1'b0;
    end else if (w_pop) begin
      r_par_err <= w_head_par ^ even_par(64'(w_head_word));
    end
  end
  assign par_err = r_par_err;
`endif

  assign op_code   = r_ir[INSTR_W-1 -: OP_W];
  assign reg_sel   = r_ir[INSTR_W-OP_W-1 -: REG_W];
  assign data      = r_ir[DATA_W-1:0];
  assign ir_valid  = r_ir_valid;
  assign underflow = r_underflow;

endmodule

`default_nettype wire
